// File: rtl/jtopl_pkg.sv
// rtl/jtopl_pkg.sv - register map, bit positions and busy FSM state type for the OPL timer front end
package jtopl_pkg;

  localparam logic [7:0] REG_TMR_A    = 8'h02;
  localparam logic [7:0] REG_TMR_B    = 8'h03;
  localparam logic [7:0] REG_TMR_CTRL = 8'h04;

  localparam int IRQ_RST = 7;
  localparam int MASK_A  = 6;
  localparam int MASK_B  = 5;
  localparam int ST_B    = 1;
  localparam int ST_A    = 0;

  localparam int STAT_IRQ  = 7;
  localparam int STAT_A    = 6;
  localparam int STAT_B    = 5;
  localparam int STAT_BUSY = 0;

  typedef enum logic {
    BUSY_IDLE = 1'b0,
    BUSY_RUN  = 1'b1
  } busy_state_t;

endpackage

// File: rtl/jtopl_timer_ctrl_if.sv
// rtl/jtopl_timer_ctrl_if.sv - host bus bundle: write strobe, address/data port, status read, irq and busy
interface jtopl_timer_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic       addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_n;
  logic       busy;

  modport master (output cs_n, wr_n, addr, din, input dout, irq_n, busy);
  modport slave  (input cs_n, wr_n, addr, din, output dout, irq_n, busy);
endinterface

// File: rtl/jtopl_busy_cnt.sv
// rtl/jtopl_busy_cnt.sv - write-busy interval FSM; counts cen ticks after each address or data write
import jtopl_pkg::*;

module jtopl_busy_cnt #(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic wr_ev,
  input  logic addr,
  output logic busy
);

  localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW       = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] ADDR_LD = CW'(ADDR_WAIT);
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_WAIT);

  busy_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BUSY_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A write on the terminal cen still reloads; a zero wait never enters BUSY.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (wr_ev) begin
      cnt_nx   = addr ? DATA_LD : ADDR_LD;
      state_nx = (cnt_nx != '0) ? BUSY_RUN : BUSY_IDLE;
    end else if (state == BUSY_RUN && cen) begin
      if (cnt <= CW'(1)) begin
        cnt_nx   = '0;
        state_nx = BUSY_IDLE;
      end else begin
        cnt_nx = cnt - 1'b1;
      end
    end
  end

  assign busy = (state == BUSY_RUN);

endmodule

// File: rtl/jtopl_timer_ctrl.sv
// rtl/jtopl_timer_ctrl.sv - OPL timer register front end: write decode, preload/control regs, status and irq
// Optional write-busy model built when JTOPL_BUSY_EN is defined.
import jtopl_pkg::*;

module jtopl_timer_ctrl #(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  jtopl_timer_ctrl_if.slave    host,
  input  logic                 flag_A,
  input  logic                 flag_B,
  output logic [7:0]           value_A,
  output logic [7:0]           value_B,
  output logic                 load_A,
  output logic                 load_B,
  output logic                 clr_flag_A,
  output logic                 clr_flag_B
);

  logic       wr_act, wr_l, wr_ev;
  logic [7:0] sel;
  logic       mask_A, mask_B;
  logic       st_A, st_B, irq;
  logic       busy_bit;
  logic [7:0] status;

  // One event per strobe, however long it is held.
  assign wr_act = ~host.cs_n & ~host.wr_n;
  assign wr_ev  = wr_act & ~wr_l;

  assign st_A = flag_A & ~mask_A;
  assign st_B = flag_B & ~mask_B;
  assign irq  = st_A | st_B;

  always_comb begin
    status            = '0;
    status[STAT_IRQ]  = irq;
    status[STAT_A]    = st_A;
    status[STAT_B]    = st_B;
    status[STAT_BUSY] = busy_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_l       <= 1'b0;
      sel        <= '0;
      value_A    <= '0;
      value_B    <= '0;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      mask_A     <= 1'b0;
      mask_B     <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      host.dout  <= '0;
    end else begin
      wr_l       <= wr_act;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      host.dout  <= status;
      if (wr_ev) begin
        if (!host.addr) begin
          sel <= host.din;
        end else begin
          case (sel)
            REG_TMR_A: value_A <= host.din;
            REG_TMR_B: value_B <= host.din;
            REG_TMR_CTRL: begin
              if (host.din[IRQ_RST]) begin
                clr_flag_A <= 1'b1;
                clr_flag_B <= 1'b1;
              end else begin
                mask_A <= host.din[MASK_A];
                mask_B <= host.din[MASK_B];
                load_B <= host.din[ST_B];
                load_A <= host.din[ST_A];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef JTOPL_BUSY_EN
  jtopl_busy_cnt #(
    .ADDR_WAIT (ADDR_WAIT),
    .DATA_WAIT (DATA_WAIT)
  ) u_busy_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .wr_ev (wr_ev),
    .addr  (host.addr),
    .busy  (busy_bit)
  );
`else
  logic unused_cen;
  localparam int unused_waits = ADDR_WAIT + DATA_WAIT;
  assign unused_cen = cen;
  assign busy_bit   = 1'b0;
`endif

  assign host.busy  = busy_bit;
  assign host.irq_n = ~irq;

endmodule

// File: doc/jtopl_timer_ctrl.md
# jtopl_timer_ctrl

CPU-side control and status front end for the OPL timer pair: it decodes the address/data write protocol, holds the timer preload and control registers, and drives the value/load/clear-flag inputs of the timer block. It also consumes the timer flags to build the status byte and the interrupt line. It sits between the host bus interface and the timer block, and optionally models the chip's write-busy interval.

## Interface
Parameters
- ADDR_WAIT, 12: cen ticks of busy after an address write
- DATA_WAIT, 84: cen ticks of busy after a data write

Ports
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable for busy counting
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low
- addr  in  1  0 = address port, 1 = data port
- din  in  8  write data
- dout  out  8  status byte, registered
- flag_A, flag_B  in  1  timer overflow flags from timer block
- value_A, value_B  out  8  timer preload values (regs 0x02, 0x03)
- load_A, load_B  out  1  timer run bits (reg 0x04 bit0, bit1)
- clr_flag_A, clr_flag_B  out  1  one-cycle flag clear pulses
- irq_n  out  1  interrupt, active low
- busy  out  1  write-busy indication

## Operation
- Write detection:
  - wr_act = ~cs_n & ~wr_n, registered into wr_l.
  - A write event occurs on the first clk where wr_act=1 and wr_l=0, so exactly one event per strobe regardless of pulse length.
- Address write (addr=0): selected register index sel <= din.
- Data write (addr=1), decoded on sel:
  - 0x02: value_A <= din.
  - 0x03: value_B <= din.
  - 0x04, din[7]=1: IRQ reset. clr_flag_A and clr_flag_B pulse high for one clk. Mask and load bits are unchanged.
  - 0x04, din[7]=0: mask_A <= din[6], mask_B <= din[5], load_B <= din[1], load_A <= din[0].
  - Any other sel: ignored.
- Status:
  - st_A = flag_A & ~mask_A.
  - st_B = flag_B & ~mask_B.
  - irq = st_A | st_B.
  - dout <= {irq, st_A, st_B, 4'b0, busy_bit}. busy_bit is defined under Configuration.
  - irq_n = ~irq, combinational from the flag inputs and registered masks.
- Setting a mask hides that flag but does not clear it. Clearing the mask re-exposes a flag that is still pending.
- Writes are never blocked by busy. A write during busy is accepted and reloads the busy counter.
- Reset values:
  - sel=0, value_A=0, value_B=0, load_A=0, load_B=0, mask_A=0, mask_B=0.
  - clr_flag_A=0, clr_flag_B=0, dout=0, busy=0, wr_l=0, busy counter=0.

## Timing
- Write event to register update: 1 clk. value_*, load_* and masks are visible the clk after the strobe edge is sampled.
- clr_flag_* pulses high during the same clk that the registers would update. Pulse width is exactly 1 clk.
- Flag input to dout: 1 clk. Flag input to irq_n: 0 clk (combinational).
- Busy FSM, two states:
  - IDLE -> BUSY on any write event. The counter loads ADDR_WAIT or DATA_WAIT according to addr.
  - In BUSY, the counter decrements on each cen. The FSM returns to IDLE when the counter reaches 0 on a cen.
  - busy=1 while in BUSY.
  - A new write event in BUSY reloads the counter and stays in BUSY.
  - A write event on the same clk as the terminal cen wins: the counter reloads.
- The counter width is sized to hold the larger of ADDR_WAIT and DATA_WAIT. A parameter value of 0 gives no busy interval.
- An rst_n assertion mid-busy or mid-strobe returns the block to reset values immediately. A strobe still held low at deassertion counts as a new event, because wr_l resets to 0.

## Configuration
- JTOPL_BUSY_EN defined:
  - The busy counter and FSM are built.
  - busy and dout[0] reflect the FSM state.
- JTOPL_BUSY_EN undefined:
  - No counter logic is built.
  - busy is tied to 0 and dout[0] is tied to 0.
  - ADDR_WAIT and DATA_WAIT are unused.
  - All other behaviour is identical.

## Structure
- Shared package jtopl_pkg:
  - Register index constants: REG_TMR_A=8'h02, REG_TMR_B=8'h03, REG_TMR_CTRL=8'h04.
  - Control bit positions: IRQ_RST=7, MASK_A=6, MASK_B=5, ST_B=1, ST_A=0.
  - Status bit positions.
- Sub-module jtopl_busy_cnt holds the busy FSM and counter.
  - Inputs: clk, rst_n, cen, wr_ev, addr.
  - Output: busy.
  - Instantiated only under JTOPL_BUSY_EN.

## Test plan
- Preload: write addr 0x02, then data 0xA5 -> value_A=0xA5 one clk after the data strobe, value_B still 0. Repeat on 0x03 with 0x3C -> value_B=0x3C.
- Control: write 0x04, then data 0x03 -> load_A=1, load_B=1. Force flag_A=1 -> irq_n=0 immediately and dout=0x C0 one clk later.
- Mask: write 0x04 with data 0x41, holding flag_A=1 -> dout[6]=0 and irq_n=1. Write 0x04 with data 0x01 -> dout=0xC0 again.
- IRQ reset: write 0x04 with data 0x80 -> clr_flag_A=clr_flag_B=1 for exactly 1 clk, and load/mask unchanged.
- Strobe handling: hold wr_n low for 10 clk on a data write -> a single register update, a single clr pulse, no repeats.
- Busy (macro on, cen every clk): address write -> busy=1 for 12 clk. Data write after 5 clk -> busy extends to 84 clk from the second write. Assert rst_n low mid-busy -> busy=0 and all registers 0.
